spell_sequencer: RTL and testbench
==================================

Name: spell_sequencer

Overview:
Multi-cycle controller that sequences the SPELL combinational execute unit. It fetches opcodes from program memory, presents them to the execute unit and commits its results (pc, sp, stack-write strobe). It stalls on data/program memory writes and implements the delay (","), sleep ("z") and stop (0xFF) behaviours. It also arbitrates host-injected out-of-order opcodes against normal fetch.

Parameters:
DELAY_PRESCALE, 16'd1000, clk cycles per unit of delay_amount (must be ≥1)
PRESCALE_W, 16, width of the prescale counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = free-running fetch/execute
wake  in  1  pulse; exits SLEEP
inject_valid  in  1  host opcode available
inject_opcode  in  8  host opcode
inject_ready  out  1  1-cycle pulse when injected opcode commits
prog_rd_en  out  1  1-cycle read strobe, address = pc
prog_rd_valid  in  1  read data valid (≥1 cycle after strobe)
prog_rd_data  in  8  program byte
opcode  out  8  to execute unit
out_of_order_exec  out  1  to execute unit; 1 while an injected opcode is in EXEC
pc  out  8  program counter register
sp  out  5  stack pointer register
ex_next_pc  in  8  from execute unit
ex_next_sp  in  5  from execute unit
ex_stack_write_count  in  2  from execute unit
ex_memory_write_en  in  1  from execute unit
ex_delay_amount  in  8  from execute unit
ex_sleep  in  1  from execute unit
ex_stop  in  1  from execute unit
stack_we  out  1  1-cycle commit strobe to stack (when stack_write_count != 0)
mem_wr_req  out  1  write request; held until ack
mem_wr_ack  in  1  write accepted
state  out  3  current FSM state (debug)
halted  out  1  1 in HALT

Behaviour:
- Reset: state=IDLE; pc=0, sp=0, opcode=0; all strobes 0; out_of_order_exec=0; delay counters 0; halted=0.
- IDLE:
  - inject_valid → EXEC, opcode=inject_opcode, ooo=1.
  - else run → FETCH.
- FETCH:
  - Pulse prog_rd_en on the entry cycle only, then wait for prog_rd_valid.
  - On valid: latch prog_rd_data into opcode, ooo=0 → EXEC.
  - inject_valid is sampled only at IDLE and on post-commit dispatch; injection has priority over fetch.
- EXEC:
  - If ex_memory_write_en: hold mem_wr_req=1 and stay in EXEC; commit only in the cycle mem_wr_ack=1.
  - Otherwise commit on the first EXEC cycle.
  - Commit: pc←ex_next_pc, sp←ex_next_sp (5-bit wrap, no fault), stack_we=1 if ex_stack_write_count != 0, inject_ready=1 if ooo.
  - Dispatch priority after commit: ex_stop→HALT; ex_sleep→SLEEP; ex_delay_amount≠0→DELAY; inject_valid→EXEC (injected); run→FETCH; else IDLE.
- DELAY:
  - Waits exactly ex_delay_amount × DELAY_PRESCALE cycles (latched at commit), then follows the same dispatch as post-commit (minus stop/sleep/delay).
  - delay_amount=0 skips DELAY.
  - run=0 does not abort DELAY.
- SLEEP:
  - wake=1 → dispatch.
  - wake coincident with entry cycle is ignored.
- HALT: halted=1. Leaves to IDLE only when run=0 and inject_valid=0.
- Latency: fetched instruction = 1 (FETCH strobe) + read latency + 1 (EXEC). Injected instruction from IDLE commits 1 cycle after acceptance.
- reset mid-operation: aborts pending mem_wr_req the next cycle; no commit occurs.
- Outputs are registered except opcode/out_of_order_exec (registers feeding the execute unit directly).

Optional Feature:
SPELL_RETIRE_COUNT_EN:
- Defined: adds output retired [15:0], reset 0, +1 per commit (including injected), wraps at 16'hFFFF→0.
- Undefined: port absent, no counter logic.

Decomposition:
- spell_pkg: state encoding (IDLE=0, FETCH=1, EXEC=2, DELAY=3, SLEEP=4, HALT=5), OP_STOP=8'hFF, PC_W=8, SP_W=5.
- Sub-module spell_delay_timer: load/count/done for the prescaler × delay_amount nested counters.

Test Plan:
- Program "1 2 +" then 0xFF with run=1, read latency 1 → three commits, pc 0→1→2→3; sp 0→1→2→1; then HALT with halted=1 and pc=4.
- EXEC with ex_memory_write_en=1, ack delayed 3 cycles → mem_wr_req high exactly 4 cycles; pc/sp unchanged until the ack cycle.
- ex_delay_amount=3, DELAY_PRESCALE=4 → next prog_rd_en exactly 12 cycles after DELAY entry; with ex_delay_amount=0, no DELAY state.
- ex_sleep=1 → SLEEP; wake pulse 10 cycles later → FETCH next cycle; wake on entry cycle alone keeps SLEEP.
- IDLE, run=0, inject_valid with opcode "5", ex_next_pc=pc → out_of_order_exec=1, inject_ready pulse, pc unchanged, sp+1, returns to IDLE.
- Assert reset while mem_wr_req pending → next cycle state=IDLE, pc=0, sp=0, mem_wr_req=0, no stack_we.

Source files
------------

// File: rtl/spell_pkg.sv
// spell_pkg: state encoding and datapath widths shared by the SPELL sequencer.
package spell_pkg;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_DELAY = 3'd3,
      S_SLEEP = 3'd4,
      S_HALT  = 3'd5
   } state_t;
   localparam logic [7:0] OP_STOP = 8'hFF;
   localparam int PC_W = 8;
   localparam int SP_W = 5;
endpackage

// File: rtl/spell_delay_timer.sv
// spell_delay_timer: nested prescaler x amount down-counter; done marks the last wait cycle.
module spell_delay_timer #(
   parameter int PRESCALE_W = 16,
   parameter logic [PRESCALE_W-1:0] DELAY_PRESCALE = 16'd1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] amount,
   output logic       done
);
   logic [7:0] unit_q, unit_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   always_comb begin
      unit_d = unit_q;
      pre_d  = pre_q;
      if (load) begin
         unit_d = amount;
         pre_d  = DELAY_PRESCALE - 1'b1;
      end else if (unit_q != 8'd0) begin
         pre_d  = (pre_q == '0) ? DELAY_PRESCALE - 1'b1 : pre_q - 1'b1;
         unit_d = (pre_q == '0) ? unit_q - 8'd1 : unit_q;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         unit_q <= 8'd0;
         pre_q  <= '0;
      end else begin
         unit_q <= unit_d;
         pre_q  <= pre_d;
      end
   end
   assign done = unit_q == 8'd1 && pre_q == '0;
endmodule

// File: rtl/spell_sequencer.sv
// spell_sequencer: fetch/exec/commit controller for the SPELL execute unit.
// Define SPELL_RETIRE_COUNT_EN to add the 16-bit retired-instruction counter output.
module spell_sequencer
   import spell_pkg::*;
#(
   parameter int PRESCALE_W = 16,
   parameter logic [PRESCALE_W-1:0] DELAY_PRESCALE = 16'd1000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic            wake,
   input  logic            inject_valid,
   input  logic [7:0]      inject_opcode,
   output logic            inject_ready,
   output logic            prog_rd_en,
   input  logic            prog_rd_valid,
   input  logic [7:0]      prog_rd_data,
   output logic [7:0]      opcode,
   output logic            out_of_order_exec,
   output logic [PC_W-1:0] pc,
   output logic [SP_W-1:0] sp,
   input  logic [PC_W-1:0] ex_next_pc,
   input  logic [SP_W-1:0] ex_next_sp,
   input  logic [1:0]      ex_stack_write_count,
   input  logic            ex_memory_write_en,
   input  logic [7:0]      ex_delay_amount,
   input  logic            ex_sleep,
   input  logic            ex_stop,
   output logic            stack_we,
   output logic            mem_wr_req,
   input  logic            mem_wr_ack,
   output logic [2:0]      state,
   output logic            halted
`ifdef SPELL_RETIRE_COUNT_EN
   ,output logic [15:0]    retired
`endif
);
   state_t state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic [7:0] opcode_q, opcode_d;
   logic ooo_q, ooo_d;
   logic inject_ready_q, inject_ready_d, stack_we_q, stack_we_d, mem_wr_req_q, mem_wr_req_d;
   logic prog_rd_en_q, halted_q, sleep_first_q;
   logic commit, go, stop, delay_done;
   assign stop   = ex_stop || opcode_q == OP_STOP;
   assign commit = state_q == S_EXEC && (!ex_memory_write_en || (mem_wr_req_q && mem_wr_ack));
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      sp_d           = sp_q;
      opcode_d       = opcode_q;
      ooo_d          = ooo_q;
      go             = 1'b0;
      inject_ready_d = 1'b0;
      stack_we_d     = 1'b0;
      mem_wr_req_d   = state_q == S_EXEC && ex_memory_write_en && !commit;
      case (state_q)
         S_IDLE:  go = 1'b1;
         S_FETCH: if (prog_rd_valid) begin
            opcode_d = prog_rd_data;
            ooo_d    = 1'b0;
            state_d  = S_EXEC;
         end
         S_EXEC:  if (commit) begin
            pc_d           = ex_next_pc;
            sp_d           = ex_next_sp;
            stack_we_d     = ex_stack_write_count != 2'd0;
            inject_ready_d = ooo_q;
            ooo_d          = 1'b0;
            state_d        = stop ? S_HALT : ex_sleep ? S_SLEEP : ex_delay_amount != 8'd0 ? S_DELAY : state_q;
            go             = !stop && !ex_sleep && ex_delay_amount == 8'd0;
         end
         S_DELAY: go = delay_done;
         S_SLEEP: go = wake && !sleep_first_q;
         S_HALT:  state_d = (!run && !inject_valid) ? S_IDLE : S_HALT;
         default: state_d = S_IDLE;
      endcase
      // common dispatch: injection wins over fetch
      if (go) begin
         state_d = inject_valid ? S_EXEC : run ? S_FETCH : S_IDLE;
         if (inject_valid) begin
            opcode_d = inject_opcode;
            ooo_d    = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         pc_q           <= '0;
         sp_q           <= '0;
         opcode_q       <= 8'd0;
         ooo_q          <= 1'b0;
         inject_ready_q <= 1'b0;
         stack_we_q     <= 1'b0;
         mem_wr_req_q   <= 1'b0;
         prog_rd_en_q   <= 1'b0;
         halted_q       <= 1'b0;
         sleep_first_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         sp_q           <= sp_d;
         opcode_q       <= opcode_d;
         ooo_q          <= ooo_d;
         inject_ready_q <= inject_ready_d;
         stack_we_q     <= stack_we_d;
         mem_wr_req_q   <= mem_wr_req_d;
         prog_rd_en_q   <= state_d == S_FETCH && state_q != S_FETCH;
         halted_q       <= state_d == S_HALT;
         sleep_first_q  <= state_d == S_SLEEP && state_q != S_SLEEP;
      end
   end
   spell_delay_timer #(
      .PRESCALE_W     (PRESCALE_W),
      .DELAY_PRESCALE (DELAY_PRESCALE)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (state_d == S_DELAY && state_q != S_DELAY),
      .amount (ex_delay_amount),
      .done   (delay_done)
   );
`ifdef SPELL_RETIRE_COUNT_EN
   logic [15:0] retired_q, retired_d;
   assign retired_d = retired_q + {15'd0, commit};
   always_ff @(posedge clk) begin
      if (reset) retired_q <= 16'd0;
      else retired_q <= retired_d;
   end
   assign retired = retired_q;
`endif
   assign state             = state_q;
   assign pc                = pc_q;
   assign sp                = sp_q;
   assign opcode            = opcode_q;
   assign out_of_order_exec = ooo_q;
   assign inject_ready      = inject_ready_q;
   assign stack_we          = stack_we_q;
   assign mem_wr_req        = mem_wr_req_q;
   assign prog_rd_en        = prog_rd_en_q;
   assign halted            = halted_q;
endmodule

// File: tb/tb_spell_sequencer.sv
// tb_spell_sequencer: execute-unit/memory models plus a commit scoreboard around spell_sequencer.
module tb_spell_sequencer;
   import spell_pkg::*;
   logic clk = 1'b0, reset = 1'b1, run = 1'b0, wake = 1'b0, inject_valid = 1'b0;
   logic [7:0] inject_opcode = 8'd0;
   logic inject_ready, prog_rd_en, out_of_order_exec, stack_we, mem_wr_req, mem_wr_ack, halted;
   logic prog_rd_valid = 1'b0;
   logic [7:0] prog_rd_data = 8'd0, opcode, pc, ex_next_pc, ex_delay_amount;
   logic [4:0] sp, ex_next_sp;
   logic [1:0] ex_stack_write_count;
   logic ex_memory_write_en, ex_sleep, ex_stop;
   logic [2:0] state;
   logic [7:0] prog [256];
   logic [7:0] delay_amt = 8'd0;
   int ack_dly = 3, req_cnt = 0, cyc = 0, checks = 0, errors = 0;
   typedef struct { logic [7:0] pc; logic [4:0] sp; logic we; logic ir; } exp_t;
   exp_t sbq[$];
   exp_t em;
   bit pend = 0;
   typedef struct { logic [7:0] op; logic [4:0] sp; logic we; } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   spell_sequencer #(.PRESCALE_W(16), .DELAY_PRESCALE(16'd4)) dut (
      .clk(clk), .reset(reset), .run(run), .wake(wake),
      .inject_valid(inject_valid), .inject_opcode(inject_opcode), .inject_ready(inject_ready),
      .prog_rd_en(prog_rd_en), .prog_rd_valid(prog_rd_valid), .prog_rd_data(prog_rd_data),
      .opcode(opcode), .out_of_order_exec(out_of_order_exec), .pc(pc), .sp(sp),
      .ex_next_pc(ex_next_pc), .ex_next_sp(ex_next_sp), .ex_stack_write_count(ex_stack_write_count),
      .ex_memory_write_en(ex_memory_write_en), .ex_delay_amount(ex_delay_amount),
      .ex_sleep(ex_sleep), .ex_stop(ex_stop), .stack_we(stack_we),
      .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .state(state), .halted(halted)
   );

   // execute unit model: digits push, '+' pops two pushes one, 'M' stores, ',' delays, 'z' sleeps
   always_comb begin
      ex_next_pc = out_of_order_exec ? pc : pc + 8'd1;
      ex_next_sp = sp;
      ex_stack_write_count = 2'd0;
      ex_memory_write_en = 1'b0;
      ex_delay_amount = 8'd0;
      ex_sleep = 1'b0;
      ex_stop = 1'b0;
      if (opcode >= "0" && opcode <= "9") begin
         ex_next_sp = sp + 5'd1;
         ex_stack_write_count = 2'd1;
      end else if (opcode == "+") begin
         ex_next_sp = sp - 5'd1;
         ex_stack_write_count = 2'd1;
      end else if (opcode == "M") begin
         ex_memory_write_en = 1'b1;
         ex_next_sp = sp - 5'd1;
      end else if (opcode == ",") ex_delay_amount = delay_amt;
      else if (opcode == "z") ex_sleep = 1'b1;
      else if (opcode == 8'hFF) ex_stop = 1'b1;
   end

   always @(posedge clk) begin
      prog_rd_valid <= prog_rd_en;
      prog_rd_data  <= prog[pc];
      req_cnt       <= mem_wr_req ? req_cnt + 1 : 0;
      cyc           <= cyc + 1;
   end
   assign mem_wr_ack = mem_wr_req && req_cnt == ack_dly;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] p, input logic [4:0] s, input logic we, input logic ir);
      exp_t e;
      e.pc = p; e.sp = s; e.we = we; e.ir = ir;
      sbq.push_back(e);
   endtask

   // scoreboard: a commit cycle is followed by registered pc/sp/strobe updates one cycle later
   always @(negedge clk) begin
      if (pend) begin
         chk("commit_expected", sbq.size() != 0, 1);
         if (sbq.size() != 0) begin
            em = sbq.pop_front();
            chk("commit_pc", pc, em.pc);
            chk("commit_sp", sp, em.sp);
            chk("commit_stack_we", stack_we, em.we);
            chk("commit_inject_ready", inject_ready, em.ir);
         end
         pend = 0;
      end
      if (!reset && state == S_EXEC && (!ex_memory_write_en || mem_wr_ack)) pend = 1;
   end

   task automatic wait_state(input logic [2:0] s, input string nm);
      int n = 0;
      while (state !== s && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(nm, state, s);
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; inject_valid = 1'b0; wake = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic finish_halt(input string nm);
      wait_state(S_HALT, nm);
      run = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, t0;
      bit saw;
      for (int i = 0; i < 256; i++) prog[i] = 8'h20;
      tbl[0] = '{"5", 5'd1, 1'b1};
      tbl[1] = '{"7", 5'd2, 1'b1};
      tbl[2] = '{"+", 5'd1, 1'b1};
      tbl[3] = '{8'h20, 5'd1, 1'b0};
      tbl[4] = '{"+", 5'd0, 1'b1};
      tbl[5] = '{"+", 5'd31, 1'b1};
      repeat (2) @(negedge clk);
      chk("rst_state", state, S_IDLE);
      chk("rst_pc", pc, 0);
      chk("rst_sp", sp, 0);
      chk("rst_opcode", opcode, 0);
      chk("rst_ooo", out_of_order_exec, 0);
      chk("rst_strobes", {prog_rd_en, stack_we, inject_ready, mem_wr_req}, 0);
      chk("rst_halted", halted, 0);
      reset = 1'b0;

      // "1 2 +" then stop
      prog[0] = "1"; prog[1] = "2"; prog[2] = "+"; prog[3] = 8'hFF;
      push(1, 1, 1, 0); push(2, 2, 1, 0); push(3, 1, 1, 0); push(4, 1, 0, 0);
      run = 1'b1;
      wait_state(S_HALT, "t1_halt");
      @(negedge clk);
      chk("t1_halted", halted, 1);
      chk("t1_pc", pc, 4);
      repeat (3) @(negedge clk);
      chk("t1_halt_hold", state, S_HALT);
      run = 1'b0;
      @(negedge clk);
      chk("t1_halt_exit", state, S_IDLE);
      chk("t1_halted_clr", halted, 0);

      // memory write held until a delayed ack; sp wraps below zero
      do_reset();
      prog[0] = "M"; prog[1] = 8'hFF; ack_dly = 3;
      push(1, 31, 0, 0); push(2, 31, 0, 0);
      run = 1'b1;
      n = 0;
      while (!mem_wr_req && n < 50) begin @(negedge clk); n++; end
      k = 0;
      while (mem_wr_req && k < 50) begin
         chk("t2_pc_hold", pc, 0);
         chk("t2_sp_hold", sp, 0);
         k++;
         @(negedge clk);
      end
      chk("t2_req_cycles", k, 4);
      finish_halt("t2_halt");

      // delay of 3 x prescale 4, run dropped mid-delay
      do_reset();
      prog[0] = ","; prog[1] = 8'hFF; delay_amt = 8'd3;
      push(1, 0, 0, 0); push(2, 0, 0, 0);
      run = 1'b1;
      wait_state(S_DELAY, "t3_delay_entry");
      t0 = cyc;
      run = 1'b0;
      repeat (5) @(negedge clk);
      chk("t3_run0_keeps_delay", state, S_DELAY);
      run = 1'b1;
      n = 0;
      while (!prog_rd_en && n < 100) begin @(negedge clk); n++; end
      chk("t3_delay_len", cyc - t0, 12);
      finish_halt("t3_halt");

      // zero delay never visits DELAY
      do_reset();
      delay_amt = 8'd0;
      push(1, 0, 0, 0); push(2, 0, 0, 0);
      run = 1'b1;
      saw = 0; n = 0;
      while (state !== S_HALT && n < 100) begin
         if (state == S_DELAY) saw = 1;
         @(negedge clk);
         n++;
      end
      chk("t3z_halt", state, S_HALT);
      chk("t3z_no_delay", saw, 0);
      run = 1'b0;
      repeat (2) @(negedge clk);

      // sleep: wake on entry ignored, later wake dispatches to fetch
      do_reset();
      prog[0] = "z"; prog[1] = 8'hFF;
      push(1, 0, 0, 0); push(2, 0, 0, 0);
      run = 1'b1;
      wait_state(S_SLEEP, "t4_sleep_entry");
      wake = 1'b1;
      @(negedge clk);
      wake = 1'b0;
      chk("t4_entry_wake_ignored", state, S_SLEEP);
      repeat (9) @(negedge clk);
      chk("t4_still_sleep", state, S_SLEEP);
      wake = 1'b1;
      @(negedge clk);
      wake = 1'b0;
      chk("t4_wake_fetch", state, S_FETCH);
      chk("t4_wake_rd_en", prog_rd_en, 1);
      finish_halt("t4_halt");

      // injected opcodes from IDLE with run low
      do_reset();
      for (int i = 0; i < 6; i++) begin
         inject_valid = 1'b1;
         inject_opcode = tbl[i].op;
         push(0, tbl[i].sp, tbl[i].we, 1);
         @(negedge clk);
         chk("t5_exec", state, S_EXEC);
         chk("t5_ooo", out_of_order_exec, 1);
         chk("t5_opcode", opcode, tbl[i].op);
         inject_valid = 1'b0;
         @(negedge clk);
         chk("t5_back_idle", state, S_IDLE);
         chk("t5_pc_same", pc, 0);
         @(negedge clk);
      end

      // injection beats fetch when both requested in IDLE
      do_reset();
      prog[0] = 8'hFF;
      inject_valid = 1'b1; inject_opcode = "9"; run = 1'b1;
      push(0, 1, 1, 1); push(1, 1, 0, 0);
      @(negedge clk);
      chk("t6_inject_first", state, S_EXEC);
      chk("t6_ooo", out_of_order_exec, 1);
      inject_valid = 1'b0;
      finish_halt("t6_halt");

      // reset while a write request is pending
      do_reset();
      prog[0] = "M"; ack_dly = 20;
      run = 1'b1;
      n = 0;
      while (!mem_wr_req && n < 50) begin @(negedge clk); n++; end
      chk("t7_req_seen", mem_wr_req, 1);
      reset = 1'b1;
      run = 1'b0;
      @(negedge clk);
      chk("t7_state", state, S_IDLE);
      chk("t7_pc", pc, 0);
      chk("t7_sp", sp, 0);
      chk("t7_req_drop", mem_wr_req, 0);
      chk("t7_no_stack_we", stack_we, 0);
      do_reset();
      @(negedge clk);
      chk("sb_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
